// File: rtl/note_recorder_pkg.sv
// rtl/note_recorder_pkg.sv - shared encodings and helpers for the note recorder
package note_recorder_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_REC  = 2'd1,
      MODE_PLAY = 2'd2
   } mode_e;

   localparam int         NOTE_W    = 5;
   localparam logic [4:0] NOTE_REST = 5'd0;
   localparam logic [4:0] NOTE_MAX  = 5'd21;

   function automatic int entry_w(input int dur_w);
      return NOTE_W + dur_w;
   endfunction

   function automatic logic [4:0] sanitize_note(input logic [4:0] n);
      return (n > NOTE_MAX) ? NOTE_REST : n;
   endfunction

endpackage

// File: rtl/note_buffer_ram.sv
// rtl/note_buffer_ram.sv - run-length entry buffer, one write port, one synchronous read port
module note_buffer_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 13
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - records the live key stream as {note, duration} runs and replays it
// NOTE_RECORDER_LOOP_EN: playback wraps from the last entry to entry 0 instead of ending
module note_recorder
   import note_recorder_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [4:0]                 key_note,
   input  logic                       rec_start,
   input  logic                       play_start,
   input  logic                       stop,
   output logic [4:0]                 music,
   output logic [1:0]                 mode,
   output logic [$clog2(DEPTH):0]     rec_len,
   output logic                       full
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int EW    = entry_w(DUR_W);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] RUN_MAX  = {DUR_W{1'b1}};
   localparam logic [DUR_W-1:0] RUN_LAST = {{(DUR_W-1){1'b1}}, 1'b0};

   mode_e            mode_q, mode_d;
   logic [4:0]       music_q, music_d;
   logic [4:0]       cur_q, cur_d;
   logic [DUR_W-1:0] run_q, run_d;
   logic [DUR_W-1:0] rem_q, rem_d;
   logic [CW-1:0]    len_q, len_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [EW-1:0]    head_q, head_d;

   logic             tick;
   logic [4:0]       key_s;
   logic             wr_en;
   logic [EW-1:0]    wr_data;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [EW-1:0]    rd_data;

   assign tick    = (pre_q == PRE_LAST);
   assign key_s   = sanitize_note(key_note);
   assign wr_addr = len_q[AW-1:0];
   // Prefetch the entry after the current one so a note change lands exactly on its tick.
   assign rd_addr = (mode_q == MODE_PLAY) ? rd_ptr_q + 1'b1 : AW'(1);

   note_buffer_ram #(
      .DEPTH(DEPTH),
      .WIDTH(EW)
   ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

   always_comb begin
      mode_d   = mode_q;
      music_d  = music_q;
      cur_d    = cur_q;
      run_d    = run_q;
      rem_d    = rem_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;
      pre_d    = tick ? '0 : pre_q + 1'b1;
      wr_en    = 1'b0;
      wr_data  = {cur_q, run_q};

      case (mode_q)
         MODE_IDLE: begin
            music_d = key_s;
            if (!stop) begin
               if (rec_start) begin
                  mode_d = MODE_REC;
                  len_d  = '0;
                  cur_d  = key_s;
                  run_d  = '0;
                  pre_d  = '0;
               end else if (play_start && len_q != '0) begin
                  mode_d   = MODE_PLAY;
                  music_d  = head_q[EW-1 -: NOTE_W];
                  rem_d    = head_q[DUR_W-1:0];
                  rd_ptr_d = '0;
                  pre_d    = '0;
               end
            end
         end

         MODE_REC: begin
            music_d = key_s;
            if (stop || key_s != cur_q) begin
               // Zero-length runs are key-bounce glitches and never reach the buffer.
               if (run_q != '0) wr_en = 1'b1;
               cur_d = key_s;
               run_d = '0;
               if (stop) mode_d = MODE_IDLE;
            end else if (tick) begin
               if (run_q == RUN_LAST) begin
                  wr_en   = 1'b1;
                  wr_data = {cur_q, RUN_MAX};
                  run_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            if (wr_en) begin
               len_d = len_q + 1'b1;
               if (len_q == CW'(DEPTH - 1)) mode_d = MODE_IDLE;
            end
         end

         MODE_PLAY: begin
            if (stop) begin
               music_d = NOTE_REST;
               mode_d  = MODE_IDLE;
            end else if (tick) begin
               if (rem_q != DUR_W'(1)) begin
                  rem_d = rem_q - 1'b1;
               end else if (({1'b0, rd_ptr_q} + 1'b1) == len_q) begin
`ifdef NOTE_RECORDER_LOOP_EN
                  music_d  = head_q[EW-1 -: NOTE_W];
                  rem_d    = head_q[DUR_W-1:0];
                  rd_ptr_d = '0;
`else
                  music_d = NOTE_REST;
                  mode_d  = MODE_IDLE;
`endif
               end else begin
                  music_d  = rd_data[EW-1 -: NOTE_W];
                  rem_d    = rd_data[DUR_W-1:0];
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end

         default: begin
            mode_d  = MODE_IDLE;
            music_d = NOTE_REST;
         end
      endcase

      // Entry 0 is shadowed so playback can start without waiting on the RAM read.
      if (wr_en && wr_addr == '0) head_d = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= MODE_IDLE;
         music_q  <= NOTE_REST;
         cur_q    <= NOTE_REST;
         run_q    <= '0;
         rem_q    <= '0;
         len_q    <= '0;
         rd_ptr_q <= '0;
         pre_q    <= '0;
         head_q   <= '0;
      end else begin
         mode_q   <= mode_d;
         music_q  <= music_d;
         cur_q    <= cur_d;
         run_q    <= run_d;
         rem_q    <= rem_d;
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         pre_q    <= pre_d;
         head_q   <= head_d;
      end
   end

   assign music   = music_q;
   assign mode    = mode_q;
   assign rec_len = len_q;
   assign full    = (len_q == CW'(DEPTH));

endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - directed self-checking bench for note_recorder (DEPTH=4, DUR_W=4, TICK_DIV=4)
module tb_note_recorder;

   localparam int DEPTH    = 4;
   localparam int DUR_W    = 4;
   localparam int TICK_DIV = 4;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    key_note = 5'd0;
   logic          rec_start = 1'b0;
   logic          play_start = 1'b0;
   logic          stop = 1'b0;
   logic [4:0]    music;
   logic [1:0]    mode;
   logic [CW-1:0] rec_len;
   logic          full;

   int checks = 0;
   int errors = 0;

   note_recorder #(
      .DEPTH(DEPTH),
      .DUR_W(DUR_W),
      .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_note(key_note),
      .rec_start(rec_start),
      .play_start(play_start),
      .stop(stop),
      .music(music),
      .mode(mode),
      .rec_len(rec_len),
      .full(full)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic r, input logic p, input logic s);
      rec_start  = r;
      play_start = p;
      stop       = s;
      cyc(1);
      rec_start  = 1'b0;
      play_start = 1'b0;
      stop       = 1'b0;
   endtask

   task automatic expect_run(input int note, input int n);
      for (int i = 0; i < n; i++) begin
         chk("play_music", int'(music), note);
         cyc(1);
      end
   endtask

   task automatic play_end(input int first);
`ifdef NOTE_RECORDER_LOOP_EN
      chk("loop_wrap_music", int'(music), first);
      chk("loop_wrap_mode", int'(mode), 2);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
`endif
      chk("end_music", int'(music), 0);
      chk("end_mode", int'(mode), 0);
   endtask

   initial begin
      cyc(2);
      chk("rst_mode", int'(mode), 0);
      chk("rst_music", int'(music), 0);
      chk("rst_len", int'(rec_len), 0);
      chk("rst_full", int'(full), 0);
      rst = 1'b0;
      cyc(1);
      chk("post_rst_mode", int'(mode), 0);
      chk("post_rst_len", int'(rec_len), 0);

      key_note = 5'd9;
      cyc(1);
      chk("idle_mirror", int'(music), 9);
      key_note = 5'd25;
      cyc(1);
      chk("idle_sanitize", int'(music), 0);
      key_note = 5'd0;
      pulse(0, 1, 0);
      chk("play_empty_mode", int'(mode), 0);

      // basic record: 12 cycles of 3, 8 cycles of 10
      key_note = 5'd3;
      pulse(1, 0, 0);
      chk("rec_mode", int'(mode), 1);
      cyc(12);
      key_note = 5'd10;
      cyc(8);
      chk("basic_len_mid", int'(rec_len), 1);
      pulse(0, 0, 1);
      chk("basic_stop_mode", int'(mode), 0);
      chk("basic_len", int'(rec_len), 2);
      chk("basic_full", int'(full), 0);
      key_note = 5'd0;
      pulse(0, 1, 0);
      chk("play_mode", int'(mode), 2);
      expect_run(3, 12);
      expect_run(10, 8);
      play_end(3);
      chk("len_kept", int'(rec_len), 2);

      pulse(0, 1, 1);
      chk("stop_beats_play", int'(mode), 0);

      // stop mid-play, key ignored during play
      key_note = 5'd5;
      pulse(0, 1, 0);
      chk("play_ignores_key", int'(music), 3);
      cyc(5);
      chk("play_ignores_key2", int'(music), 3);
      pulse(0, 0, 1);
      chk("stop_play_music", int'(music), 0);
      chk("stop_play_mode", int'(mode), 0);
      cyc(1);
      chk("idle_after_stop", int'(music), 5);

      // reset during play
      key_note = 5'd0;
      pulse(0, 1, 0);
      cyc(3);
      chk("pre_rst_mode", int'(mode), 2);
      rst = 1'b1;
      #1;
      chk("async_rst_mode", int'(mode), 0);
      chk("async_rst_music", int'(music), 0);
      chk("async_rst_len", int'(rec_len), 0);
      cyc(1);
      rst = 1'b0;
      cyc(2);
      chk("rel_rst_mode", int'(mode), 0);
      chk("rel_rst_len", int'(rec_len), 0);
      chk("rel_rst_music", int'(music), 0);

      // glitch filter
      key_note = 5'd1;
      pulse(1, 0, 0);
      cyc(8);
      key_note = 5'd5;
      cyc(2);
      chk("glitch_len_mid", int'(rec_len), 1);
      key_note = 5'd1;
      cyc(8);
      chk("glitch_len_pre", int'(rec_len), 1);
      pulse(0, 0, 1);
      chk("glitch_len", int'(rec_len), 2);
      key_note = 5'd0;
      pulse(0, 1, 0);
      expect_run(1, 16);
      play_end(1);

      // saturation split
      key_note = 5'd7;
      pulse(1, 0, 0);
      cyc(64);
      chk("sat_len_mid", int'(rec_len), 1);
      pulse(0, 0, 1);
      chk("sat_len", int'(rec_len), 2);
      key_note = 5'd0;
      pulse(0, 1, 0);
      expect_run(7, 64);
      play_end(7);

      // fill the buffer
      key_note = 5'd2;
      pulse(1, 0, 0);
      cyc(4);
      key_note = 5'd4;
      cyc(4);
      key_note = 5'd6;
      cyc(4);
      key_note = 5'd8;
      cyc(4);
      chk("fill_len3", int'(rec_len), 3);
      chk("fill_not_full", int'(full), 0);
      chk("fill_mode_rec", int'(mode), 1);
      key_note = 5'd11;
      cyc(1);
      chk("full_mode", int'(mode), 0);
      chk("full_len", int'(rec_len), 4);
      chk("full_flag", int'(full), 1);
      chk("full_mirror", int'(music), 11);
      cyc(3);
      key_note = 5'd13;
      cyc(4);
      chk("full_len_hold", int'(rec_len), 4);
      key_note = 5'd17;
      pulse(0, 1, 0);
      expect_run(2, 4);
      expect_run(4, 4);
      expect_run(6, 4);
      expect_run(8, 4);
      play_end(2);
      chk("full_len_kept", int'(rec_len), 4);
      chk("full_flag_kept", int'(full), 1);
      cyc(1);
      chk("idle_resume", int'(music), 17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Upstream stage of the seven-segment note display and the buzzer driver.
- Captures the live keyboard note stream as run-length entries {note, duration} in an internal buffer.
- Replays that buffer on request.
- Drives a registered 5-bit music code: 0 = rest, 1..21 = low/mid/high 1..7.
- In IDLE, music mirrors the live key so the display and buzzer stay responsive.

Parameters:
- DEPTH, 64, number of buffer entries (power of two).
- DUR_W, 8, duration field width, in ticks.
- TICK_DIV, 1_000_000, clock cycles per tick (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- key_note  input  5  live note from keyboard decoder; values >21 treated as 0
- rec_start  input  1  one-cycle pulse: begin recording
- play_start  input  1  one-cycle pulse: begin playback
- stop  input  1  one-cycle pulse: end recording or playback
- music  output  5  note code to display/buzzer stages
- mode  output  2  0 IDLE, 1 REC, 2 PLAY
- rec_len  output  $clog2(DEPTH)+1  number of valid stored entries
- full  output  1  high when rec_len == DEPTH

Behaviour:
- Reset (async, rst=1) clears all state:
  - mode = IDLE, music = 0, rec_len = 0, full = 0.
  - Prescaler, run counter and pointers = 0.
  - Buffer contents are don't-care.
- Reset mid-record or mid-play aborts immediately; the recording is lost.
- Tick: the prescaler counts 0..TICK_DIV-1; tick pulses for one cycle at wrap. The prescaler clears on every entry to REC or PLAY.
- Command priority in a single cycle: stop > rec_start > play_start.
- Commands that do not apply to the current state are ignored:
  - rec_start or play_start in REC or PLAY.
  - stop in IDLE.
- IDLE:
  - music <= sanitized key_note each cycle (1-cycle latency).
  - rec_start -> REC: rec_len <= 0, cur_note <= key_note, run <= 0.
  - play_start with rec_len == 0 -> stays IDLE.
  - play_start with rec_len > 0 -> PLAY.
- REC:
  - music mirrors key_note as in IDLE.
  - On tick, run increments.
  - When key_note != cur_note, the entry {cur_note, run} is written at index rec_len and rec_len increments; then cur_note <= key_note, run <= 0.
  - Entries with run == 0 are discarded (glitch filter); rec_len does not change.
  - When run reaches 2^DUR_W-1 on a tick, the entry is written and run restarts at 0 with the same cur_note (saturation split).
  - stop flushes the pending run (same zero-drop rule), then -> IDLE.
  - A write that makes rec_len == DEPTH forces -> IDLE the same cycle. Later key changes are not stored.
  - A key change and stop in the same cycle produce exactly one write (the pending run).
- PLAY:
  - On entry: rd_ptr = 0, entry 0 is loaded, music = entry0.note from the cycle after play_start, remaining = entry0.dur.
  - remaining decrements on each tick. When it reaches 0 with no tick pending, the next cycle loads entry rd_ptr+1.
  - After entry rec_len-1 expires: music <= 0, -> IDLE.
  - stop: music <= 0 next cycle, -> IDLE.
  - key_note is ignored in PLAY.
- rec_len is preserved across PLAY and IDLE; it is only cleared by a new rec_start or by rst.
- The buffer is a synchronous-read RAM (one cycle read latency), inferable as distributed or block RAM. The controller accounts for the read latency so the note boundaries above hold exactly.

Optional Feature:
- Macro: NOTE_RECORDER_LOOP_EN.
- Defined:
  - On expiry of the last entry, playback wraps to entry 0 seamlessly: no rest cycle, and music changes exactly on the tick boundary.
  - Only stop or rst leave PLAY.
- Undefined: playback ends in IDLE with music = 0, as above.

Decomposition:
- Shared package ppppparameters, extended with:
  - mode encodings MODE_IDLE, MODE_REC, MODE_PLAY.
  - NOTE_REST = 0 and NOTE_MAX = 21.
  - the entry record width (5 + DUR_W).
- One sub-module, note_buffer_ram: single-port write, single-port synchronous read, DEPTH x (5+DUR_W).
- The controller FSM, tick prescaler and counters stay in note_recorder.

Test Plan (TICK_DIV=4, DEPTH=4, DUR_W=4):
- Reset: assert rst mid-PLAY -> mode=0, music=0, rec_len=0 in the same cycle; these values hold after release.
- Basic record:
  - Stimulus: rec_start; key=3 for 12 cycles, key=10 for 8 cycles, stop.
  - Response: rec_len=2, entries {3,3} and {10,2}.
  - Then play_start: music=3 for 12 cycles, 10 for 8 cycles, then 0, mode=0.
- Glitch filter: in REC, a key=5 pulse of 2 cycles between key=1 runs -> no entry for 5; rec_len counts only the two runs of key=1.
- Saturation: hold key=7 for 16 ticks (64 cycles), then stop -> entries {7,15} and {7,1}, rec_len=2.
- Full:
  - Stimulus: record 5 distinct notes, each 1 tick.
  - Response: rec_len=4, full=1, mode returns to 0 after the 4th write; the 5th note is not stored.
- Priority and empty-buffer cases:
  - stop and play_start together in IDLE -> stays IDLE.
  - play_start with rec_len=0 -> stays IDLE.
  - With LOOP_EN, the last entry wraps to entry 0 with no music=0 gap.
